bcd_counter_mux7seg: RTL and testbench

//  Parametrised multi-digit BCD up/down counter with a time-multiplexed 7-segment display driver.
//  - Holds DIGITS decimal digits and counts up or down with BCD carry/borrow, with parallel load and terminal-count pulse.
//  - Scans the digits onto one shared active-low segment bus plus per-digit active-low anodes.
//  - Sits between the board's sync counter logic and the 7-seg display; generalises the single-digit combinational BCD decoder.

---
 rtl/bcd_counter_mux7seg.sv | 146 ++++++++++++++
 tb/tb_bcd_counter_mux7seg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_mux7seg.sv
// Multi-digit BCD up/down counter with load and terminal-count pulse,
// driving a time-multiplexed active-low 7-segment display.
module bcd_counter_mux7seg #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int unsigned CNT_W = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]  count_q, count_d;
    logic              tc_q, tc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Counter next state: load sanitises non-BCD nibbles; a step ripples carry/borrow.
    logic       carry;
    logic [3:0] nib;
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        carry   = 1'b0;
        nib     = 4'd0;
        if (load) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                nib = load_val[4*i +: 4];
                count_d[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
            end
        end else if (en) begin
            carry = 1'b1;
            for (int i = 0; i < int'(DIGITS); i++) begin
                nib = count_q[4*i +: 4];
                if (carry) begin
                    if (up) begin
                        if (nib == 4'd9) begin
                            count_d[4*i +: 4] = 4'd0;
                        end else begin
                            count_d[4*i +: 4] = nib + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) begin
                            count_d[4*i +: 4] = 4'd9;
                        end else begin
                            count_d[4*i +: 4] = nib - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            tc_d = carry;
        end
    end

    // Scan prescaler and digit index, free-running regardless of en/load.
    always_comb begin
        presc_d = presc_q + PS_W'(1);
        idx_d   = idx_q;
        if (presc_q == PS_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // upper_zero[i]: digits i..DIGITS-1 are all zero (leading-zero candidate).
    logic [DIGITS-1:0] upper_zero;
    logic              all_zero;
    logic [3:0]        sel_nib;
    logic              sel_blank;
    always_comb begin
        upper_zero = '0;
        all_zero   = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero      = all_zero & (count_q[4*i +: 4] == 4'd0);
            upper_zero[i] = all_zero;
        end
        an_d      = '1;
        sel_nib   = 4'd0;
        sel_blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                an_d[i]   = 1'b0;
                sel_nib   = count_q[4*i +: 4];
                sel_blank = (BLANK_LZ != 0) && (i > 0) && upper_zero[i];
            end
        end
        seg_d = sel_blank ? 7'b1111111 : seg_decode(sel_nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            idx_q   <= '0;
            presc_q <= '0;
            an_q    <= '1;
            seg_q   <= 7'b1111111;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign an    = an_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_bcd_counter_mux7seg.sv
// Scoreboard bench for bcd_counter_mux7seg: blanking and non-blanking instances
// share stimulus; expectations are queued per cycle and checked by a monitor.
module tb_bcd_counter_mux7seg;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] load_val;
    logic [15:0] count, count_b;
    logic        tc, tc_b;
    logic [3:0]  an, an_b;
    logic [6:0]  seg, seg_b;

    bcd_counter_mux7seg #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .tc(tc), .an(an), .seg(seg)
    );

    bcd_counter_mux7seg #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) u_nobl (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count_b), .tc(tc_b), .an(an_b), .seg(seg_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       name;
        int          mask;   // bit0: count/tc, bit1: an/seg
        logic [15:0] cnt;
        logic        tcv;
        logic [3:0]  anv;
        logic [6:0]  sega;
        logic [6:0]  segb;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: pops every expectation due this cycle and compares.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: check missed, due %0d now %0d", e.name, e.due, cyc);
            end else begin
                if (e.mask[0]) begin
                    chk({e.name, ".count"},   32'(count),   32'(e.cnt));
                    chk({e.name, ".tc"},      32'(tc),      32'(e.tcv));
                    chk({e.name, ".count_b"}, 32'(count_b), 32'(e.cnt));
                    chk({e.name, ".tc_b"},    32'(tc_b),    32'(e.tcv));
                end
                if (e.mask[1]) begin
                    chk({e.name, ".an"},    32'(an),    32'(e.anv));
                    chk({e.name, ".seg"},   32'(seg),   32'(e.sega));
                    chk({e.name, ".an_b"},  32'(an_b),  32'(e.anv));
                    chk({e.name, ".seg_b"}, 32'(seg_b), 32'(e.segb));
                end
            end
        end
    end

    task automatic drive(input logic r, input logic l, input logic e, input logic u,
                         input logic [15:0] v);
        rst = r; load = l; en = e; up = u; load_val = v;
    endtask

    task automatic push(input string nm, input int mask, input logic [15:0] c, input logic t,
                        input logic [3:0] a, input logic [6:0] sa, input logic [6:0] sbv);
        exp_t x;
        x.due = cyc + 1; x.name = nm; x.mask = mask; x.cnt = c; x.tcv = t;
        x.anv = a; x.sega = sa; x.segb = sbv;
        sb.push_back(x);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // One counter cycle: drive, expect count/tc after the next edge.
    task automatic step(input string nm, input logic l, input logic e, input logic u,
                        input logic [15:0] v, input logic [15:0] c, input logic t);
        drive(1'b0, l, e, u, v);
        push(nm, 1, c, t, 4'hF, 7'h7F, 7'h7F);
        tick();
    endtask

    // Reset, then load val on release and follow the full 4-digit scan.
    // sa/sbp hold the expected per-digit segments {d3,d2,d1,d0} for each instance.
    task automatic scan_run(input string nm, input logic [15:0] val,
                            input logic [27:0] sa, input logic [27:0] sbp);
        logic [3:0] a;
        int         d;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        push({nm, ".rst"}, 3, 16'h0, 1'b0, 4'hF, 7'h7F, 7'h7F);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, val);
        for (int k = 1; k <= 17; k++) begin
            if (k == 1) begin
                push($sformatf("%s.k%0d", nm, k), 3, val, 1'b0, 4'b1110, 7'b0000001, 7'b0000001);
            end else begin
                d = ((k - 1) / 4) % 4;
                a = 4'b1111;
                a[d] = 1'b0;
                push($sformatf("%s.k%0d", nm, k), 2, val, 1'b0, a, sa[7*d +: 7], sbp[7*d +: 7]);
            end
            tick();
            drive(1'b0, 1'b0, 1'b0, 1'b0, val);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            push($sformatf("reset%0d", i), 3, 16'h0, 1'b0, 4'hF, 7'h7F, 7'h7F);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        push("release", 3, 16'h0, 1'b0, 4'b1110, 7'b0000001, 7'b0000001);
        tick();

        // Carry and up-wrap
        step("ld0999",  1'b1, 1'b0, 1'b1, 16'h0999, 16'h0999, 1'b0);
        step("up0999",  1'b0, 1'b1, 1'b1, 16'h0000, 16'h1000, 1'b0);
        step("ld9999",  1'b1, 1'b0, 1'b1, 16'h9999, 16'h9999, 1'b0);
        step("up9999",  1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);
        step("hold0",   1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
        // Borrow and down-wrap
        step("ld1000",  1'b1, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0);
        step("dn1000",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0999, 1'b0);
        step("ld0000",  1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        step("dn0000",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1);
        step("dn9999",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h9998, 1'b0);
        step("up9998",  1'b0, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b0);
        step("upwrap",  1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1);
        step("ld00AF",  1'b1, 1'b0, 1'b0, 16'h00AF, 16'h0000, 1'b0);
        step("ld0AB3",  1'b1, 1'b0, 1'b0, 16'h0AB3, 16'h0003, 1'b0);
        step("dir_up",  1'b0, 1'b1, 1'b1, 16'h0000, 16'h0004, 1'b0);
        step("dir_dn",  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0003, 1'b0);
        // Priority: load over en, reset over load
        step("ld_en",   1'b1, 1'b1, 1'b1, 16'h0042, 16'h0042, 1'b0);
        step("ld_en9",  1'b1, 1'b1, 1'b1, 16'h9999, 16'h9999, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0042);
        push("rst_ld", 3, 16'h0000, 1'b0, 4'hF, 7'h7F, 7'h7F);
        tick();

        scan_run("scan42", 16'h0042,
                 {7'b1111111, 7'b1111111, 7'b1001100, 7'b0010010},
                 {7'b0000001, 7'b0000001, 7'b1001100, 7'b0010010});
        scan_run("scan07", 16'h0007,
                 {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111},
                 {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111});

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
